dispense_count_tx: RTL and testbench
====================================

Name: dispense_count_tx

Overview:
Dispense controller that drives the count handshake consumed by the two-digit seven-segment display block (count2 / count_ACK2).
- Detects a debounced hand-present sensor and runs the pump for one fixed-length dose.
- Emits one count_ACK2 pulse per completed dose and keeps its own running dose total.
- Sits between the sensor/pump I/O and the display.

Parameters:
DOSE_CYCLES, 16, pump-on duration per dose in clk cycles (>=2)
ACK_HIGH, 4, count_ACK2 high width in cycles (>=1)
ACK_LOW, 4, minimum count_ACK2 low gap after each pulse (>=1)
MAX_COUNT, 99, dose total saturation value (two-digit display limit)
DEBOUNCE, 3, consecutive synchronized-high cycles required to accept sensor

Ports:
clk  in  1  system clock
RESET  in  1  synchronous, active-low reset (one clock; reset sampled only on clk rising edge)
sensor  in  1  hand-present input, asynchronous to clk
tank_empty  in  1  level, already synchronous; 1 = no liquid
pump_en  out  1  pump drive, registered
count2  out  1  counting-enabled level to display
count_ACK2  out  1  one pulse per completed dose, registered
dose_total  out  7  running dose count, 0..MAX_COUNT
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RESET=0 at a rising edge): state=IDLE and all outputs 0 (pump_en, count2, count_ACK2, busy, dose_total). Sync/debounce flops are cleared. A reset mid-dose kills pump_en at that same edge.
- count2: goes to 1 at the first edge with RESET=1. It stays 1 until saturation (see below), then stays 0 until the next reset.
- Sensor path: 2-flop synchronizer, then a debounce counter. sensor_q sets at the DEBOUNCE-th consecutive high synchronized sample. Any low sample clears the counter and sensor_q in the same cycle.
- Latency: sensor sampled high at edge 1 gives sensor_q=1 after edge 2+DEBOUNCE, and pump_en=1 after edge 3+DEBOUNCE (edge 6 at defaults).
- FSM states: IDLE, PUMP, ACK_HI, ACK_LO, HOLD.
  - IDLE -> PUMP when sensor_q && !tank_empty && count2. Loads the pump timer; pump_en=1 from entry.
  - PUMP: pump_en high for exactly DOSE_CYCLES cycles, then -> ACK_HI.
  - PUMP, tank_empty=1 sampled: -> HOLD at that edge, pump_en=0, no ACK, no increment. This takes priority over timer expiry in the same cycle.
  - PUMP, sensor_q drops: ignored; the dose completes.
  - ACK_HI: count_ACK2=1 for exactly ACK_HIGH cycles. dose_total increments on the entry edge (same edge count_ACK2 rises). Then -> ACK_LO.
  - ACK_LO: count_ACK2=0 for exactly ACK_LOW cycles, then -> HOLD.
  - HOLD: waits for sensor_q=0 (one dose per hand presentation), then -> IDLE. If sensor_q is already 0, HOLD lasts exactly one cycle.
- Saturation:
  - dose_total never wraps.
  - When dose_total == MAX_COUNT at ACK_LO exit, count2 falls on that edge.
  - IDLE then ignores the sensor permanently; only reset restarts.
- tank_empty in IDLE blocks starts. It has no effect in ACK_HI, ACK_LO or HOLD.
- dose_total is unsigned, width 7; the MAX_COUNT parameter must be <= 127.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package: FSM state encoding and default constants (DOSE_CYCLES, ACK_HIGH, ACK_LOW, MAX_COUNT, DEBOUNCE), so the display block and the top level agree on pulse widths and the limit.
- One sub-module: input_debounce, containing the 2-flop sync, the DEBOUNCE counter and the sensor_q output (clk and RESET ported through).
- Pump and ACK timers share one down-counter inside dispense_count_tx.

Test Plan:
1. Reset: hold RESET=0 for 2 edges with sensor=1 -> all outputs 0. Release -> count2=1 next edge, pump_en still 0 until the debounce completes.
2. Single dose at defaults: sensor held high -> pump_en high exactly 16 cycles starting edge 6, then count_ACK2 high 4 cycles and low 4 cycles, dose_total=1. No second dose while sensor stays high. Drop sensor 1 cycle and re-present -> dose_total=2.
3. Glitch: sensor high 2 cycles, low, high 1 cycle -> pump_en never asserts, dose_total=0.
4. Empty tank: tank_empty=1 at the 5th PUMP cycle -> pump_en=0 on that edge, no count_ACK2 pulse, dose_total unchanged, FSM in HOLD until sensor drops. Start with tank_empty=1 -> no pump.
5. Saturation with MAX_COUNT=3: three doses -> dose_total=3 and count2 falls at the edge ending ACK_LO. A 4th presentation produces no pump_en and no pulse.
6. Reset mid-ACK_HI (2nd pulse cycle) -> count_ACK2, dose_total and busy are 0 at that edge. After release, a normal dose gives dose_total=1.

Source files
------------

// File: rtl/dispense_count_tx_pkg.sv
// Shared constants and FSM encoding for the dispense controller and the
// display block that consumes its count2 / count_ACK2 handshake.
package dispense_count_tx_pkg;

    localparam int DEF_DOSE_CYCLES = 16;
    localparam int DEF_ACK_HIGH    = 4;
    localparam int DEF_ACK_LOW     = 4;
    localparam int DEF_MAX_COUNT   = 99;
    localparam int DEF_DEBOUNCE    = 3;
    localparam int TOTAL_W         = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUMP,
        ST_ACK_HI,
        ST_ACK_LO,
        ST_HOLD
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dispense_count_tx_debounce.sv
// Sensor conditioning: 2-flop synchronizer followed by a run-length debounce.
// sensor_q rises on the DEBOUNCE-th consecutive high sample, drops on any low.
module input_debounce
    import dispense_count_tx_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic RESET,
    input  logic sensor,
    output logic sensor_q
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!RESET) begin
            sync_pipe <= '0;
            cnt       <= '0;
            sensor_q  <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], sensor};
            if (!sync_pipe[1]) begin
                cnt      <= '0;
                sensor_q <= 1'b0;
            end else begin
                // Counter parks at DEBOUNCE so a long hand presence cannot wrap it.
                if (cnt != CW'(DEBOUNCE))
                    cnt <= cnt + CW'(1);
                if (cnt >= CW'(DEBOUNCE - 1))
                    sensor_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispense_count_tx.sv
// Dispense controller: one fixed dose per hand presentation, then a count_ACK2
// pulse to the display and a saturating running total.
module dispense_count_tx
    import dispense_count_tx_pkg::*;
#(
    parameter int DOSE_CYCLES = DEF_DOSE_CYCLES,
    parameter int ACK_HIGH    = DEF_ACK_HIGH,
    parameter int ACK_LOW     = DEF_ACK_LOW,
    parameter int MAX_COUNT   = DEF_MAX_COUNT,
    parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               sensor,
    input  logic               tank_empty,
    output logic               pump_en,
    output logic               count2,
    output logic               count_ACK2,
    output logic [TOTAL_W-1:0] dose_total,
    output logic               busy
);

    // Timer holds (duration - 1), so the widest phase needs clog2(max) bits.
    localparam int TW = $clog2(max3(DOSE_CYCLES, ACK_HIGH, ACK_LOW));
    localparam logic [TOTAL_W-1:0] MAX_TOTAL = TOTAL_W'(MAX_COUNT);

    state_t        state, next_state;
    logic [TW-1:0] timer, timer_next;
    logic          sensor_q;
    logic          inc_total;
    logic          sat, sat_set;

    input_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk      (clk),
        .RESET    (RESET),
        .sensor   (sensor),
        .sensor_q (sensor_q)
    );

    always_comb begin
        next_state = state;
        timer_next = timer;
        inc_total  = 1'b0;
        sat_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sensor_q && !tank_empty && count2) begin
                    next_state = ST_PUMP;
                    timer_next = TW'(DOSE_CYCLES - 1);
                end
            end
            ST_PUMP: begin
                // A dry tank aborts the dose even on the timer's final cycle.
                if (tank_empty) begin
                    next_state = ST_HOLD;
                end else if (timer == '0) begin
                    next_state = ST_ACK_HI;
                    timer_next = TW'(ACK_HIGH - 1);
                    inc_total  = 1'b1;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_ACK_HI: begin
                if (timer == '0) begin
                    next_state = ST_ACK_LO;
                    timer_next = TW'(ACK_LOW - 1);
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_ACK_LO: begin
                if (timer == '0) begin
                    next_state = ST_HOLD;
                    sat_set    = (dose_total == MAX_TOTAL);
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_HOLD: begin
                if (!sensor_q)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            timer      <= '0;
            dose_total <= '0;
            sat        <= 1'b0;
            pump_en    <= 1'b0;
            count2     <= 1'b0;
            count_ACK2 <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= next_state;
            timer <= timer_next;
            if (inc_total && dose_total != MAX_TOTAL)
                dose_total <= dose_total + TOTAL_W'(1);
            sat        <= sat | sat_set;
            count2     <= !(sat | sat_set);
            // Outputs are decoded from next_state so they change on the same edge as the state.
            pump_en    <= (next_state == ST_PUMP);
            count_ACK2 <= (next_state == ST_ACK_HI);
            busy       <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dispense_count_tx.sv
// Bench for dispense_count_tx: directed scenarios plus random sensor traffic,
// checked against a dose-timeline reference model.
module tb_dispense_count_tx;

    localparam int D    = 16;
    localparam int AH   = 4;
    localparam int AL   = 4;
    localparam int MAXC = 3;
    localparam int DEB  = 3;

    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic       sensor = 1'b0;
    logic       tank_empty = 1'b0;
    logic       pump_en, count2, count_ACK2, busy;
    logic [6:0] dose_total;
    logic [10:0] dut_vec;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dispense_count_tx #(
        .DOSE_CYCLES(D), .ACK_HIGH(AH), .ACK_LOW(AL), .MAX_COUNT(MAXC), .DEBOUNCE(DEB)
    ) u_dut (
        .clk(clk), .RESET(RESET), .sensor(sensor), .tank_empty(tank_empty),
        .pump_en(pump_en), .count2(count2), .count_ACK2(count_ACK2),
        .dose_total(dose_total), .busy(busy)
    );

    assign dut_vec = {pump_en, count2, count_ACK2, busy, dose_total};

    // Reference model: a dose is a timeline offset m_t (pump, then ACK high, then ACK low).
    int m_s1 = 0, m_s2 = 0, m_run = 0, m_sq = 0;
    int m_t = -1, m_hold = 0, m_total = 0, m_sat = 0, m_cnt2 = 0;
    int sq_old, c2_old;

    always @(posedge clk) begin
        sq_old = m_sq;
        c2_old = m_cnt2;
        if (!RESET) begin
            m_s1 = 0; m_s2 = 0; m_run = 0; m_sq = 0;
            m_t = -1; m_hold = 0; m_total = 0; m_sat = 0; m_cnt2 = 0;
        end else begin
            m_run = m_s2 ? m_run + 1 : 0;
            m_sq  = (m_run >= DEB);
            m_s2  = m_s1;
            m_s1  = sensor;
            if (m_t >= 0) begin
                if (m_t < D && tank_empty) begin
                    m_t = -1; m_hold = 1;
                end else begin
                    m_t++;
                    if (m_t == D && m_total < MAXC) m_total++;
                    if (m_t == D + AH + AL) begin
                        m_t = -1; m_hold = 1;
                        if (m_total == MAXC) m_sat = 1;
                    end
                end
            end else if (m_hold != 0) begin
                if (sq_old == 0) m_hold = 0;
            end else if (sq_old != 0 && !tank_empty && c2_old != 0) begin
                m_t = 0;
            end
            m_cnt2 = (m_sat == 0);
        end
    end

    function automatic logic [10:0] m_vec();
        logic p, a, b, c;
        logic [6:0] t;
        p = (m_t >= 0) && (m_t < D);
        a = (m_t >= D) && (m_t < D + AH);
        b = (m_t >= 0) || (m_hold != 0);
        c = (m_cnt2 != 0);
        t = 7'(m_total);
        return {p, c, a, b, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        sensor = 1'b1; tank_empty = 1'b0; RESET = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %b want 0", dut_vec); end
        RESET = 1'b1;
        tick();
        checks++;
        if (count2 !== 1'b1) begin errors++; $display("FAIL reset_count2_rise: got %b want 1", count2); end
        for (int i = 2; i <= 6; i++) begin
            tick();
            checks++;
            if (pump_en !== (i == 6)) begin errors++; $display("FAIL reset_pump_latency edge %0d: got %b want %b", i, pump_en, i == 6); end
        end
        sensor = 1'b0;
        repeat (35) begin
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin errors++; $display("FAIL reset_model: dut %b model %b", dut_vec, m_vec()); end
        end
    endtask

    task automatic test_single_dose();
        int first, pcnt, acnt;
        first = -1; pcnt = 0; acnt = 0;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        sensor = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin errors++; $display("FAIL dose_model: dut %b model %b", dut_vec, m_vec()); end
            if (pump_en) begin pcnt++; if (first < 0) first = i; end
            if (count_ACK2) acnt++;
        end
        checks++;
        if (first !== 6) begin errors++; $display("FAIL dose_pump_start: got %0d want 6", first); end
        checks++;
        if (pcnt !== D) begin errors++; $display("FAIL dose_pump_len: got %0d want %0d", pcnt, D); end
        checks++;
        if (acnt !== AH) begin errors++; $display("FAIL dose_ack_len: got %0d want %0d", acnt, AH); end
        checks++;
        if (dose_total !== 7'd1) begin errors++; $display("FAIL dose_total_1: got %0d want 1", dose_total); end
        sensor = 1'b0;
        tick();
        sensor = 1'b1;
        repeat (40) begin
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin errors++; $display("FAIL dose2_model: dut %b model %b", dut_vec, m_vec()); end
        end
        checks++;
        if (dose_total !== 7'd2) begin errors++; $display("FAIL dose_total_2: got %0d want 2", dose_total); end
    endtask

    task automatic test_glitch();
        logic [4:0] pat;
        int seen;
        pat = 5'b01011;
        seen = 0;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            sensor = (i < 5) ? pat[i] : 1'b0;
            tick();
            if (pump_en) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL glitch_pump: got %0d pump cycles want 0", seen); end
        checks++;
        if (dose_total !== 7'd0) begin errors++; $display("FAIL glitch_total: got %0d want 0", dose_total); end
    endtask

    task automatic test_empty_tank();
        int n, acks;
        n = 0; acks = 0;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        sensor = 1'b1;
        while (!pump_en && n < 20) begin tick(); n++; end
        checks++;
        if (!pump_en) begin errors++; $display("FAIL tank_wait_pump: got timeout want pump_en"); end
        repeat (4) tick();
        tank_empty = 1'b1;
        tick();
        checks++;
        if ({pump_en, busy} !== 2'b01) begin errors++; $display("FAIL tank_abort: got pump/busy %b want 01", {pump_en, busy}); end
        repeat (30) begin
            tick();
            if (count_ACK2) acks++;
            checks++;
            if (dut_vec !== m_vec()) begin errors++; $display("FAIL tank_model: dut %b model %b", dut_vec, m_vec()); end
        end
        checks++;
        if (acks !== 0 || dose_total !== 7'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL tank_hold: got acks %0d total %0d busy %b want 0 0 1", acks, dose_total, busy);
        end
        sensor = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tank_release: got busy %b want 0", busy); end
        sensor = 1'b1;
        n = 0;
        repeat (30) begin tick(); if (pump_en) n++; end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL tank_block_start: got %0d pump cycles want 0", n); end
        tank_empty = 1'b0;
        sensor = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_saturation();
        int ack_fall, c2_fall, n;
        logic pa, pc;
        ack_fall = -1; c2_fall = -1;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            sensor = 1'b1;
            repeat (32) begin
                pa = count_ACK2; pc = count2;
                tick();
                if (d == 2 && pa && !count_ACK2) ack_fall = cyc;
                if (d == 2 && pc && !count2) c2_fall = cyc;
                checks++;
                if (dut_vec !== m_vec()) begin errors++; $display("FAIL sat_model: dut %b model %b", dut_vec, m_vec()); end
            end
            sensor = 1'b0;
            repeat (3) tick();
        end
        checks++;
        if (dose_total !== 7'(MAXC) || count2 !== 1'b0) begin
            errors++; $display("FAIL sat_state: got total %0d count2 %b want %0d 0", dose_total, count2, MAXC);
        end
        checks++;
        if (c2_fall - ack_fall !== AL) begin errors++; $display("FAIL sat_count2_edge: got %0d want %0d", c2_fall - ack_fall, AL); end
        sensor = 1'b1;
        n = 0;
        repeat (40) begin tick(); if (pump_en || count_ACK2) n++; end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL sat_ignore: got %0d active cycles want 0", n); end
        sensor = 1'b0;
    endtask

    task automatic test_reset_mid_ack();
        int n;
        n = 0;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        sensor = 1'b1;
        while (!count_ACK2 && n < 40) begin tick(); n++; end
        checks++;
        if (!count_ACK2) begin errors++; $display("FAIL mid_ack_wait: got timeout want count_ACK2"); end
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if ({count_ACK2, busy, pump_en, dose_total} !== 10'd0) begin
            errors++; $display("FAIL mid_ack_reset: got ack %b busy %b total %0d want 0", count_ACK2, busy, dose_total);
        end
        RESET = 1'b1;
        repeat (40) tick();
        checks++;
        if (dose_total !== 7'd1) begin errors++; $display("FAIL mid_ack_redose: got %0d want 1", dose_total); end
    endtask

    task automatic test_random();
        int left;
        left = 0;
        sensor = 1'b0; tank_empty = 1'b0;
        apply_reset();
        repeat (1500) begin
            if (left == 0) begin
                sensor = 1'($urandom_range(0, 1));
                left = $urandom_range(1, 35);
            end
            left--;
            tank_empty = ($urandom_range(0, 29) == 0);
            RESET = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (dut_vec !== m_vec()) begin errors++; $display("FAIL random_model cyc %0d: dut %b model %b", cyc, dut_vec, m_vec()); end
        end
        RESET = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_dose();
        test_glitch();
        test_empty_tank();
        test_saturation();
        test_reset_mid_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
